// File: rtl/railway_pkg.sv
// Shared types and defaults for the railway crossing blocks.
package railway_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StOccupied,
        StClearing,
        StFault
    } state_e;

    localparam int unsigned DefDebounceCycles = 4;
    localparam int unsigned DefClearHold      = 8;
    localparam int unsigned DefTimeout        = 1000;

    localparam int unsigned CntWidth = 4;
    localparam logic [CntWidth-1:0] CntMax = 4'd15;

    // Width of a counter that runs 0..n-1, never narrower than one bit.
    function automatic int unsigned ctr_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer plus stability filter; emits a one-cycle pulse on each accepted rise.
module sensor_debounce
    import railway_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic rise_o
);

    localparam int unsigned W = ctr_width(DEBOUNCE_CYCLES);
    localparam logic [W-1:0] StableMax = W'(DEBOUNCE_CYCLES - 1);

    logic         sync1_q, sync2_q;
    logic         level_q, level_d;
    logic         rise_q, rise_d;
    logic [W-1:0] stab_q, stab_d;

    // Level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        stab_d  = '0;
        if (sync2_q != level_q) begin
            if (stab_q == StableMax) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            stab_q  <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            stab_q  <= stab_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/train_approach_detector.sv
// Counts trains between an approach and a departure sensor and requests gate closure.
module train_approach_detector
    import railway_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned CLEAR_HOLD      = DefClearHold,
    parameter int unsigned TIMEOUT         = DefTimeout
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sens_in,
    input  logic       sens_out,
    output logic       train_req,
    output logic [3:0] train_cnt,
    output logic       fault
);

    localparam int unsigned HW = ctr_width(CLEAR_HOLD);
    localparam int unsigned WW = ctr_width(TIMEOUT);
    localparam logic [HW-1:0] HoldLoad = HW'(CLEAR_HOLD - 1);
    localparam logic [WW-1:0] WdMax    = WW'(TIMEOUT - 1);

    logic arr, dep;

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_in (
        .clk   (clk),
        .reset (reset),
        .raw_i (sens_in),
        .rise_o(arr)
    );

    sensor_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_out (
        .clk   (clk),
        .reset (reset),
        .raw_i (sens_out),
        .rise_o(dep)
    );

    state_e              state_q, state_d;
    logic [CntWidth-1:0] cnt_q, cnt_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [WW-1:0]       wd_q, wd_d;
    logic                req_q, req_d;
    logic                fault_q, fault_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hold_d  = hold_q;
        wd_d    = wd_q;
        unique case (state_q)
            StIdle: begin
                if (arr && !dep) begin
                    state_d = StOccupied;
                    cnt_d   = 4'd1;
                    wd_d    = '0;
                end else if (dep && !arr) begin
                    state_d = StFault;
                end
            end
            StOccupied: begin
                if (arr || dep) begin
                    wd_d = '0;
                end else if (wd_q == WdMax) begin
                    state_d = StFault;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
                if (arr && !dep) begin
                    if (cnt_q == CntMax) begin
                        state_d = StFault;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else if (dep && !arr) begin
                    if (cnt_q == 4'd1) begin
                        cnt_d   = 4'd0;
                        state_d = StClearing;
                        hold_d  = HoldLoad;
                    end else if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
            end
            StClearing: begin
                // Departures here are trailing wheels of the train that just left.
                if (arr) begin
                    state_d = StOccupied;
                    cnt_d   = 4'd1;
                    wd_d    = '0;
                end else if (hold_q == '0) begin
                    state_d = StIdle;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            StFault: ;
            default: state_d = StIdle;
        endcase
        req_d   = (state_d != StIdle);
        fault_d = (state_d == StFault);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hold_q  <= '0;
            wd_q    <= '0;
            req_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
            wd_q    <= wd_d;
            req_q   <= req_d;
            fault_q <= fault_d;
        end
    end

    assign train_req = req_q;
    assign train_cnt = cnt_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_train_approach_detector.sv
// Directed bench for train_approach_detector with DEBOUNCE_CYCLES=4, CLEAR_HOLD=8, TIMEOUT=50.
module tb_train_approach_detector;

    logic       clk;
    logic       reset;
    logic       sens_in;
    logic       sens_out;
    logic       train_req;
    logic [3:0] train_cnt;
    logic       fault;

    int n_total = 0;
    int n_bad   = 0;

    train_approach_detector #(
        .DEBOUNCE_CYCLES(4),
        .CLEAR_HOLD     (8),
        .TIMEOUT        (50)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sens_in  (sens_in),
        .sens_out (sens_out),
        .train_req(train_req),
        .train_cnt(train_cnt),
        .fault    (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        reset    = 1'b1;
        sens_in  = 1'b0;
        sens_out = 1'b0;
        tick(2);
        check_eq("rst_req", int'(train_req), 0);
        check_eq("rst_cnt", int'(train_cnt), 0);
        check_eq("rst_fault", int'(fault), 0);
        reset = 1'b0;

        // 3-cycle glitch is rejected
        sens_in = 1'b1;
        tick(3);
        sens_in = 1'b0;
        tick(10);
        check_eq("glitch_req", int'(train_req), 0);
        check_eq("glitch_cnt", int'(train_cnt), 0);

        // Clean rise: train_req on edge 7
        sens_in = 1'b1;
        tick(6);
        check_eq("lat_e6_req", int'(train_req), 0);
        tick(1);
        check_eq("lat_e7_req", int'(train_req), 1);
        check_eq("lat_e7_cnt", int'(train_cnt), 1);
        check_eq("lat_e7_fault", int'(fault), 0);

        // Departure then 8-cycle hold
        sens_in  = 1'b0;
        sens_out = 1'b1;
        tick(6);
        check_eq("dep_e6_cnt", int'(train_cnt), 1);
        tick(1);
        check_eq("dep_cnt", int'(train_cnt), 0);
        check_eq("dep_req", int'(train_req), 1);
        tick(7);
        check_eq("hold7_req", int'(train_req), 1);
        tick(1);
        check_eq("hold8_req", int'(train_req), 0);
        sens_out = 1'b0;

        // Arrival, departure, then re-arrival at hold cycle 5
        sens_in = 1'b1;
        tick(7);
        check_eq("arr2_cnt", int'(train_cnt), 1);
        sens_in = 1'b0;
        tick(8);
        sens_out = 1'b1;
        tick(5);
        sens_in = 1'b1;
        tick(2);
        check_eq("clr2_cnt", int'(train_cnt), 0);
        tick(4);
        check_eq("clr2_h4_req", int'(train_req), 1);
        tick(1);
        check_eq("rearr_cnt", int'(train_cnt), 1);
        check_eq("rearr_req", int'(train_req), 1);
        tick(4);
        check_eq("rearr_late_req", int'(train_req), 1);
        check_eq("rearr_fault", int'(fault), 0);

        // Simultaneous arrival and departure with one train present
        sens_in  = 1'b0;
        sens_out = 1'b0;
        tick(8);
        sens_in  = 1'b1;
        sens_out = 1'b1;
        tick(7);
        check_eq("simul_cnt", int'(train_cnt), 1);
        check_eq("simul_fault", int'(fault), 0);

        // Watchdog: no events for 50 cycles
        tick(49);
        check_eq("wd49_fault", int'(fault), 0);
        tick(1);
        check_eq("wd50_fault", int'(fault), 1);
        check_eq("wd50_req", int'(train_req), 1);

        // Reset out of FAULT
        reset    = 1'b1;
        sens_in  = 1'b0;
        sens_out = 1'b0;
        tick(1);
        check_eq("rstf_req", int'(train_req), 0);
        check_eq("rstf_cnt", int'(train_cnt), 0);
        check_eq("rstf_fault", int'(fault), 0);
        reset = 1'b0;

        // Departure with empty section in IDLE
        sens_out = 1'b1;
        tick(6);
        check_eq("idep_e6_fault", int'(fault), 0);
        tick(1);
        check_eq("idep_fault", int'(fault), 1);
        check_eq("idep_req", int'(train_req), 1);
        check_eq("idep_cnt", int'(train_cnt), 0);
        sens_out = 1'b0;
        tick(20);
        check_eq("idep_sticky", int'(fault), 1);

        // Sensor high across reset release, then overflow at 16 arrivals
        reset   = 1'b1;
        sens_in = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(6);
        check_eq("rel_e6_req", int'(train_req), 0);
        tick(1);
        check_eq("rel_e7_req", int'(train_req), 1);
        check_eq("rel_e7_cnt", int'(train_cnt), 1);
        for (int i = 2; i <= 16; i++) begin
            sens_in = 1'b0;
            tick(8);
            sens_in = 1'b1;
            tick(7);
            check_eq($sformatf("ovf_cnt%0d", i), int'(train_cnt), (i > 15) ? 15 : i);
            if (i == 15) check_eq("ovf15_fault", int'(fault), 0);
        end
        check_eq("ovf_fault", int'(fault), 1);
        check_eq("ovf_req", int'(train_req), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/train_approach_detector.md
TRAIN_APPROACH_DETECTOR -- requirements
Module: train_approach_detector

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles a synchronized sensor level must hold before it is accepted.
REQ-002 Parameter CLEAR_HOLD, default 8: cycles train_req stays high after the section empties.
REQ-003 Parameter TIMEOUT, default 1000: maximum cycles the section may remain occupied with no sensor event.
REQ-004 Port clk  input  1  single system clock; all logic on the rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port sens_in  input  1  raw, asynchronous approach-sensor level; 1 means train on the sensor.
REQ-007 Port sens_out  input  1  raw, asynchronous departure-sensor level; 1 means train on the sensor.
REQ-008 Port train_req  output  1  registered gate-close request; drives the SW1 input of railway_gate_sim.
REQ-009 Port train_cnt  output  4  registered count of trains between the two sensors.
REQ-010 Port fault  output  1  registered sticky fault flag.

Function
REQ-011 Each raw sensor SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each filtered level SHALL change only after its synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any shorter glitch resets that channel's stability counter.
REQ-013 A 0->1 transition of filtered sens_in SHALL be an arrival event; a 0->1 transition of filtered sens_out SHALL be a departure event; each event is one cycle wide.
REQ-014 Latency: a clean sens_in rise, held stable, SHALL assert train_req on exactly the (DEBOUNCE_CYCLES+3)th rising clk edge after the rise.
REQ-015 train_cnt SHALL increment on an arrival and decrement on a departure; if both occur in the same cycle, it SHALL remain unchanged.
REQ-016 An arrival while train_cnt=15 SHALL leave train_cnt at 15 and enter FAULT.
REQ-017 A departure while train_cnt=0 and not in CLEARING SHALL leave train_cnt at 0 and enter FAULT.
REQ-018 FSM states and behaviour:
- IDLE: train_req=0.
- OCCUPIED: train_req=1.
- CLEARING: train_req=1; hold timer running.
- FAULT: train_req=1, fault=1.
REQ-019 IDLE->OCCUPIED on an arrival.
REQ-020 OCCUPIED->CLEARING when train_cnt transitions to 0; the hold timer loads CLEAR_HOLD-1.
REQ-021 CLEARING->IDLE when the hold timer reaches 0, so train_req is high for exactly CLEAR_HOLD cycles after train_cnt reaches 0.
REQ-022 CLEARING->OCCUPIED on an arrival; the hold timer is cancelled and train_req stays high with no glitch.
REQ-023 A departure in CLEARING SHALL be ignored (no fault, count stays 0).
REQ-024 In OCCUPIED, a watchdog counter SHALL restart on every arrival or departure event; if it reaches TIMEOUT, the FSM SHALL enter FAULT.
REQ-025 FAULT SHALL be exited only by reset (fail-safe: gate held closed).
REQ-026 Counters SHALL be sized with $clog2 of their parameter; no counter SHALL wrap.

Reset
REQ-027 On reset, on the same edge: state=IDLE, train_req=0, train_cnt=0, fault=0, all synchronizer flops, filtered levels, and stability/hold/watchdog counters cleared.
REQ-028 Reset asserted mid-operation, including in FAULT, SHALL take priority over every event in that cycle.
REQ-029 A sensor already high when reset deasserts SHALL be treated as a new rise, producing an event after the REQ-014 latency.

Structure
REQ-030 FSM state encoding and the default parameter values SHALL live in the shared package railway_pkg.
REQ-031 The synchronizer plus debounce logic SHALL be one sub-module, sensor_debounce, instantiated twice (once for sens_in, once for sens_out).
REQ-032 All outputs SHALL be driven directly from flops.

Verification (DEBOUNCE_CYCLES=4, CLEAR_HOLD=8, TIMEOUT=50)
REQ-033 Reset release, then sens_in=1 held -> train_req=1 and train_cnt=1 on edge 7 after the rise; fault=0.
REQ-034 sens_in pulse of 3 cycles -> train_req stays 0 and train_cnt stays 0.
REQ-035 Arrival, then departure -> train_cnt returns to 0 and train_req falls exactly 8 cycles later; a new arrival at hold cycle 5 keeps train_req=1 with train_cnt=1.
REQ-036 Simultaneous debounced arrival and departure with train_cnt=1 -> train_cnt stays 1; a departure at train_cnt=0 in IDLE -> fault=1 and train_req=1 until reset.
REQ-037 Arrival followed by no events for 50 cycles -> fault=1; reset asserted -> all outputs 0 on the next edge.
REQ-038 16 arrivals with no departures -> train_cnt stays 15 and fault=1.
